// File: rtl/dco_pwm_timer.sv
// dco_pwm_timer: DCO-clocked PWM generator with period-end IRQ; one-shot mode is built only when DCO_PWM_ONESHOT_EN is defined
module dco_pwm_timer #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 16
) (
  input  logic                  dco_clk,
  input  logic                  sys_rst_n,
  input  logic [DATA_WIDTH-1:0] pwm_ctrl,
  input  logic [DATA_WIDTH-1:0] pwm_period,
  input  logic [DATA_WIDTH-1:0] pwm_duty,
  output logic [DATA_WIDTH-1:0] hw_up_pwm_ctrl,
  output logic [DATA_WIDTH-1:0] hw_val_pwm_ctrl,
  output logic                  pwm_out,
  output logic                  pwm_period_irq
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
`ifdef DCO_PWM_ONESHOT_EN
  localparam logic [1:0] DONE = 2'd3;
`endif
  logic [1:0]   state_q, state_d;
  logic         on_meta_q, on_sync_q;
  logic [N-1:0] cnt_q, cnt_d, period_q, period_d, duty_q, duty_d;
  logic         pwm_q, pwm_d, irq_q, irq_d;
  logic         bnd, unused_bits;
  assign bnd         = (state_q == RUN) && (cnt_q == period_q);
  assign unused_bits = ^{pwm_ctrl, pwm_period, pwm_duty};
  // Next-state: shadows only reload at LOAD or a period boundary; losing ON in RUN aborts at once
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    duty_d   = duty_q;
    pwm_d    = 1'b0;
    irq_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = on_sync_q ? LOAD : IDLE;
      end
      LOAD: begin
        period_d = pwm_period[N-1:0];
        duty_d   = pwm_duty[N-1:0];
        cnt_d    = '0;
        state_d  = RUN;
      end
      RUN: begin
        irq_d    = bnd;
        period_d = bnd ? pwm_period[N-1:0] : period_q;
        duty_d   = bnd ? pwm_duty[N-1:0] : duty_q;
        pwm_d    = on_sync_q && (cnt_q < duty_q);
        cnt_d    = (bnd || !on_sync_q) ? '0 : cnt_q + N'(1);
`ifdef DCO_PWM_ONESHOT_EN
        state_d  = !on_sync_q ? IDLE : (bnd && pwm_ctrl[1]) ? DONE : RUN;
`else
        state_d  = on_sync_q ? RUN : IDLE;
`endif
      end
`ifdef DCO_PWM_ONESHOT_EN
      default: state_d = on_sync_q ? DONE : IDLE;
`else
      default: state_d = IDLE;
`endif
    endcase
  end
  // State, counter, shadows and the two-flop ON synchroniser
  always_ff @(posedge dco_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      on_meta_q <= 1'b0;
      on_sync_q <= 1'b0;
      cnt_q     <= '0;
      period_q  <= '0;
      duty_q    <= '0;
      pwm_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      on_meta_q <= pwm_ctrl[0];
      on_sync_q <= on_meta_q;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      duty_q    <= duty_d;
      pwm_q     <= pwm_d;
      irq_q     <= irq_d;
    end
  end
`ifdef DCO_PWM_ONESHOT_EN
  logic clr_q;
  // Marks the first DONE cycle so ON is cleared by hardware exactly once
  always_ff @(posedge dco_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) clr_q <= 1'b0;
    else clr_q <= (state_q == RUN) && (state_d == DONE);
  end
  assign hw_up_pwm_ctrl = DATA_WIDTH'({irq_q, 7'b0, clr_q});
`else
  assign hw_up_pwm_ctrl = DATA_WIDTH'({irq_q, 8'b0});
`endif
  assign hw_val_pwm_ctrl = DATA_WIDTH'({irq_q, 8'b0});
  assign pwm_out         = pwm_q ^ pwm_ctrl[2];
  assign pwm_period_irq  = irq_q;
endmodule
